// File: rtl/lock_pkg.sv
// Shared types and constants for the lock_ctrl access sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      UNLOCK  = 2'd1,
      DENY    = 2'd2,
      LOCKOUT = 2'd3
   } lock_state_t;

   // Enabled cycles between alarm toggles while locked out.
   localparam int ALARM_TOGGLE_CYCLES = 4;

   // Largest of three window lengths; sizes the shared down-counter.
   function automatic int lock_max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that times the UNLOCK/DENY/LOCKOUT windows.
// Latency: load/decrement take effect at the next edge; o_expire is combinational.
// Backpressure: none; i_en low freezes the count.
module lock_timer #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_clear,
   output logic [W-1:0] o_value,
   output logic         o_expire
);

   logic [W-1:0] r_value;

   // Load wins over clear, clear over decrement; the count saturates at zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_value <= '0;
      end else if (i_en) begin
         if (i_load) begin
            r_value <= i_load_val;
         end else if (i_clear) begin
            r_value <= '0;
         end else if (r_value != '0) begin
            r_value <= r_value - 1'b1;
         end
      end
   end

   assign o_value  = r_value;
   assign o_expire = i_en && (r_value == W'(1));

endmodule

// File: rtl/lock_ctrl.sv
// Door-unlock sequencer: timed unlock, deny indication and lockout after repeated failures.
// Latency: one registered stage; an attempt sampled at edge k drives outputs from edge k.
// Backpressure: none; attempts outside IDLE or with i_en low are dropped.
// Optional build macro LOCK_ALARM_EN adds a toggling lockout alarm; otherwise o_alarm is 0.
module lock_ctrl
   import lock_pkg::*;
#(
   parameter int UNLOCK_CYCLES  = 8,
   parameter int DENY_CYCLES    = 4,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int MAX_FAILS      = 3
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic                           i_attempt_done,
   input  logic                           i_access_granted,
   input  logic                           i_relock,
   output logic                           o_unlock,
   output logic                           o_led_green,
   output logic                           o_led_red,
   output logic                           o_lockout,
   output logic [$clog2(MAX_FAILS+1)-1:0] o_fail_count,
   output logic                           o_alarm
);

   localparam int TMAX = lock_max3(UNLOCK_CYCLES, DENY_CYCLES, LOCKOUT_CYCLES);
   localparam int TW   = $clog2(TMAX + 1);
   localparam int FW   = $clog2(MAX_FAILS + 1);

   localparam logic [TW-1:0] C_UNLOCK  = TW'(UNLOCK_CYCLES);
   localparam logic [TW-1:0] C_DENY    = TW'(DENY_CYCLES);
   localparam logic [TW-1:0] C_LOCKOUT = TW'(LOCKOUT_CYCLES);
   localparam logic [FW-1:0] C_MAXF    = FW'(MAX_FAILS);
   localparam logic [FW-1:0] C_LAST    = FW'(MAX_FAILS - 1);

   lock_state_t   r_state;
   logic          r_unlock;
   logic          r_led_green;
   logic          r_led_red;
   logic          r_lockout;
   logic [FW-1:0] r_fail_count;

   logic          w_accept;
   logic          w_last_fail;
   logic          w_lock_entry;
   logic          w_relock;
   logic          w_load;
   logic [TW-1:0] w_load_val;
   logic [TW-1:0] w_timer_value;
   logic          w_timer_zero;
   logic          w_expire;

   // Decode the accepted attempt and the timer load value for this cycle.
   always_comb begin
      w_accept     = i_en && (r_state == IDLE) && i_attempt_done;
      w_last_fail  = (r_fail_count == C_LAST);
      w_lock_entry = w_accept && !i_access_granted && w_last_fail;
      w_relock     = i_en && (r_state == UNLOCK) && i_relock;
      w_load       = w_accept;
      w_load_val   = C_DENY;
      if (i_access_granted) begin
         w_load_val = C_UNLOCK;
      end else if (w_last_fail) begin
         w_load_val = C_LOCKOUT;
      end
      // A timed state with an empty timer can only come from corruption; leave it.
      w_timer_zero = (w_timer_value == '0);
   end

   lock_timer #(
      .W (TW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_clear    (w_relock),
      .o_value    (w_timer_value),
      .o_expire   (w_expire)
   );

   // Main sequencer: state, status outputs and failure counter move together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_unlock     <= 1'b0;
         r_led_green  <= 1'b0;
         r_led_red    <= 1'b0;
         r_lockout    <= 1'b0;
         r_fail_count <= '0;
      end else if (i_en) begin
         case (r_state)
            IDLE: begin
               if (i_attempt_done) begin
                  if (i_access_granted) begin
                     r_state      <= UNLOCK;
                     r_unlock     <= 1'b1;
                     r_led_green  <= 1'b1;
                     r_fail_count <= '0;
                  end else if (w_last_fail) begin
                     r_state      <= LOCKOUT;
                     r_led_red    <= 1'b1;
                     r_lockout    <= 1'b1;
                     r_fail_count <= C_MAXF;
                  end else begin
                     r_state      <= DENY;
                     r_led_red    <= 1'b1;
                     r_fail_count <= r_fail_count + 1'b1;
                  end
               end
            end
            UNLOCK: begin
               if (i_relock || w_expire || w_timer_zero) begin
                  r_state     <= IDLE;
                  r_unlock    <= 1'b0;
                  r_led_green <= 1'b0;
               end
            end
            DENY: begin
               if (w_expire || w_timer_zero) begin
                  r_state   <= IDLE;
                  r_led_red <= 1'b0;
               end
            end
            LOCKOUT: begin
               if (w_expire || w_timer_zero) begin
                  r_state      <= IDLE;
                  r_led_red    <= 1'b0;
                  r_lockout    <= 1'b0;
                  r_fail_count <= '0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_unlock    <= 1'b0;
               r_led_green <= 1'b0;
               r_led_red   <= 1'b0;
               r_lockout   <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOCK_ALARM_EN
   localparam int ACW = $clog2(ALARM_TOGGLE_CYCLES);

   logic           r_alarm;
   logic [ACW-1:0] r_alarm_cnt;

   // Alarm rises on lockout entry, toggles every few enabled cycles, drops on exit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_alarm     <= 1'b0;
         r_alarm_cnt <= '0;
      end else if (i_en) begin
         if (w_lock_entry) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
         end else if (r_state == LOCKOUT && !(w_expire || w_timer_zero)) begin
            if (r_alarm_cnt == ACW'(ALARM_TOGGLE_CYCLES - 1)) begin
               r_alarm     <= ~r_alarm;
               r_alarm_cnt <= '0;
            end else begin
               r_alarm_cnt <= r_alarm_cnt + 1'b1;
            end
         end else begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
         end
      end
   end

   assign o_alarm = r_alarm;
`else
   logic w_unused_entry;
   assign w_unused_entry = w_lock_entry;
   assign o_alarm        = 1'b0;
`endif

   assign o_unlock     = r_unlock;
   assign o_led_green  = r_led_green;
   assign o_led_red    = r_led_red;
   assign o_lockout    = r_lockout;
   assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed, table-driven bench for lock_ctrl with default parameters.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       attempt_done;
   logic       access_granted;
   logic       relock;
   logic       unlock;
   logic       led_green;
   logic       led_red;
   logic       lockout;
   logic [1:0] fail_count;
   logic       alarm;
   logic [6:0] got;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic       ad;
      logic       ag;
      logic       rl;
      logic [6:0] exp;   // {unlock, green, red, lockout, alarm, fail_count[1:0]}
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   lock_ctrl #(
      .UNLOCK_CYCLES  (8),
      .DENY_CYCLES    (4),
      .LOCKOUT_CYCLES (16),
      .MAX_FAILS      (3)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_en             (en),
      .i_attempt_done   (attempt_done),
      .i_access_granted (access_granted),
      .i_relock         (relock),
      .o_unlock         (unlock),
      .o_led_green      (led_green),
      .o_led_red        (led_red),
      .o_lockout        (lockout),
      .o_fail_count     (fail_count),
      .o_alarm          (alarm)
   );

   assign got = {unlock, led_green, led_red, lockout, alarm, fail_count};

   // Expected alarm level in lockout cycle c (c = 1 is the cycle after entry).
   function automatic logic alm(input int c);
      logic a;
      a = (((c - 1) / 4) % 2) == 0;
`ifndef LOCK_ALARM_EN
      a = 1'b0;
`endif
      return a;
   endfunction

   function automatic void add(input logic e, input logic ad, input logic ag, input logic rl,
                               input logic u, input logic g, input logic r, input logic l,
                               input logic a, input logic [1:0] fc);
      vec_t v;
      v.en  = e;
      v.ad  = ad;
      v.ag  = ag;
      v.rl  = rl;
      v.exp = {u, g, r, l, a, fc};
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got={u,g,r,l,alarm,fc}=%b required=%b", nm, got, exp);
      end
   endtask

   task automatic step(input logic e, input logic ad, input logic ag, input logic rl);
      en             = e;
      attempt_done   = ad;
      access_granted = ag;
      relock         = rl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; attempt_done = 1'b0; access_granted = 1'b0; relock = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 7'b0);
      rst = 1'b0;

      // Quiet idle
      add(1,0,0,0, 0,0,0,0,0, 2'd0);
      // Correct code: 8 unlock cycles; attempt in cycle 4 ignored; attempt on expiry edge dropped
      add(1,1,1,0, 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 2; i++) add(1,0,0,0, 1,1,0,0,0, 2'd0);
      add(1,1,0,0, 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 4; i++) add(1,0,0,0, 1,1,0,0,0, 2'd0);
      add(1,1,1,0, 0,0,0,0,0, 2'd0);
      add(1,0,0,0, 0,0,0,0,0, 2'd0);
      // First and second wrong codes: 4 red cycles each
      add(1,1,0,0, 0,0,1,0,0, 2'd1);
      for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0,1,0,0, 2'd1);
      add(1,0,0,0, 0,0,0,0,0, 2'd1);
      add(1,1,0,0, 0,0,1,0,0, 2'd2);
      for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0,1,0,0, 2'd2);
      add(1,0,0,0, 0,0,0,0,0, 2'd2);
      // Third wrong code: 16 lockout cycles, granted attempt at cycle 8 ignored
      add(1,1,0,0, 0,0,1,1,alm(1), 2'd3);
      for (int c = 2; c <= 16; c++) add(1,(c == 8),1,0, 0,0,1,1,alm(c), 2'd3);
      add(1,0,0,0, 0,0,0,0,0, 2'd0);
      // Attempt with en low is dropped
      add(0,1,1,0, 0,0,0,0,0, 2'd0);
      // Enable freeze: 5 en-low cycles stretch unlock to 13; relock/attempt while frozen ignored
      add(1,1,1,0, 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 2; i++) add(1,0,0,0, 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 5; i++) add(0,(i == 1),0,(i == 3), 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 5; i++) add(1,0,0,0, 1,1,0,0,0, 2'd0);
      add(1,0,0,0, 0,0,0,0,0, 2'd0);
      // Relock sampled in unlock cycle 3
      add(1,1,1,0, 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 2; i++) add(1,0,0,0, 1,1,0,0,0, 2'd0);
      add(1,0,0,1, 0,0,0,0,0, 2'd0);
      // Two fails (relock ignored in IDLE and DENY), then a correct code clears fail_count
      add(1,1,0,1, 0,0,1,0,0, 2'd1);
      for (int i = 0; i < 3; i++) add(1,0,0,1, 0,0,1,0,0, 2'd1);
      add(1,0,0,0, 0,0,0,0,0, 2'd1);
      add(1,1,0,0, 0,0,1,0,0, 2'd2);
      for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0,1,0,0, 2'd2);
      add(1,0,0,0, 0,0,0,0,0, 2'd2);
      add(1,1,1,0, 1,1,0,0,0, 2'd0);
      for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1,0,0,0, 2'd0);
      add(1,0,0,0, 0,0,0,0,0, 2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].ad, vecs[i].ag, vecs[i].rl);
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset during lockout cycle 6, with en low to show reset ignores enable
      step(1,1,0,0);
      chk("seq_fail1", {5'b00100, 2'd1});
      repeat (4) step(1,0,0,0);
      chk("seq_deny1_exit", {5'b00000, 2'd1});
      step(1,1,0,0);
      repeat (4) step(1,0,0,0);
      chk("seq_deny2_exit", {5'b00000, 2'd2});
      step(1,1,0,0);
      chk("seq_lock_c1", {4'b0011, alm(1), 2'd3});
      for (int c = 2; c <= 5; c++) begin
         step(1,0,0,0);
         chk($sformatf("seq_lock_c%0d", c), {4'b0011, alm(c), 2'd3});
      end
      rst = 1'b1;
      step(0,0,0,0);
      chk("seq_rst_in_lockout", 7'b0);
      rst = 1'b0;
      step(1,0,0,0);
      chk("seq_after_rst_idle", 7'b0);
      step(1,1,0,0);
      chk("seq_after_rst_fail", {5'b00100, 2'd1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Access-control sequencer directly downstream of the keypad passcode checker. Consumes the checker's per-attempt verdict and drives the door-unlock strobe and status LEDs. Enforces a timed unlock window, a short deny indication, and a lockout period after consecutive failed attempts.

## Interface
Parameters:
- UNLOCK_CYCLES, 8: enabled cycles the unlock output stays high after a correct code (≥1).
- DENY_CYCLES, 4: enabled cycles of red indication after a wrong code (≥1).
- LOCKOUT_CYCLES, 16: enabled cycles of lockout after MAX_FAILS consecutive failures (≥1).
- MAX_FAILS, 3: consecutive failures that trigger lockout (≥1).

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  global enable; low freezes state, timer and counters.
- attempt_done  input  1  one-cycle strobe: the checker has completed a 4-digit attempt.
- access_granted  input  1  checker verdict; sampled only when attempt_done=1.
- relock  input  1  forces early exit from UNLOCK.
- unlock  output  1  door strobe, high throughout UNLOCK.
- led_green  output  1  high in UNLOCK.
- led_red  output  1  high in DENY and LOCKOUT.
- lockout  output  1  high in LOCKOUT.
- fail_count  output  $clog2(MAX_FAILS+1)  count of consecutive failures.
- alarm  output  1  lockout alarm; see Configuration.

## Operation
- States: IDLE, UNLOCK, DENY, LOCKOUT. All outputs are registered and update on the same edge as the state.
- Reset values: state IDLE; unlock, led_green, led_red, lockout, alarm, fail_count and timer all 0.
- When en=0, nothing changes. This includes the state, the timer, fail_count and alarm. attempt_done is dropped.
- IDLE, on attempt_done with en=1:
  - If access_granted=1: go to UNLOCK, load timer with UNLOCK_CYCLES, clear fail_count.
  - If access_granted=0 and fail_count+1 == MAX_FAILS: go to LOCKOUT, set fail_count to MAX_FAILS, load timer with LOCKOUT_CYCLES.
  - If access_granted=0 otherwise: increment fail_count, go to DENY, load timer with DENY_CYCLES.
- Timed states (UNLOCK, DENY, LOCKOUT):
  - The timer decrements on each enabled cycle.
  - On an enabled cycle with timer==1, go to IDLE. The state therefore lasts exactly N enabled cycles.
  - On LOCKOUT exit, fail_count clears to 0.
- attempt_done is ignored in UNLOCK, DENY and LOCKOUT. Such attempts are not counted and not queued.
- relock=1 in UNLOCK with en=1: go to IDLE on the next edge. relock is ignored in every other state.
- Simultaneous events: relock takes priority over timer expiry.
- fail_count never exceeds MAX_FAILS. It is cleared only by a granted attempt, LOCKOUT exit, or rst.
- Timer width is $clog2(max(UNLOCK_CYCLES, DENY_CYCLES, LOCKOUT_CYCLES)+1). The timer is unsigned and never underflows.

## Timing
- Latency: attempt_done sampled at edge k changes the outputs at edge k (visible in cycle k+1). This is a single registered stage.
- With en held high, unlock is high for exactly UNLOCK_CYCLES cycles. Each en=0 cycle stretches the window by one.
- rst asserted mid-operation: all outputs return to reset values at the next clk edge, regardless of en.
- A new attempt is accepted on the first edge after returning to IDLE. attempt_done coincident with the expiry edge is dropped.

## Configuration
- LOCK_ALARM_EN defined:
  - alarm goes high on LOCKOUT entry.
  - It toggles every 4 enabled cycles while in LOCKOUT.
  - It is forced to 0 on LOCKOUT exit and in all other states.
- LOCK_ALARM_EN undefined: alarm is tied to 0 and no alarm logic is built.

## Structure
- Shared package lock_pkg holds:
  - the state enum lock_state_t (IDLE, UNLOCK, DENY, LOCKOUT);
  - ALARM_TOGGLE_CYCLES = 4.
- One sub-module, lock_timer: a loadable down-counter with load, value, en and an expire flag (value==1 and en). lock_ctrl instantiates it once.

## Test plan
- Reset: assert rst for 2 cycles → all outputs 0, fail_count 0, state IDLE.
- Correct code with defaults: attempt_done=1, access_granted=1 → unlock and led_green high for exactly 8 cycles starting the cycle after the strobe, then 0.
- Three wrong codes with MAX_FAILS=3:
  - The first two attempts → fail_count 1 then 2, led_red high 4 cycles each.
  - The third attempt → lockout and led_red high 16 cycles.
  - An attempt_done pulsed during lockout is ignored.
  - fail_count reads 0 after lockout exit.
- Enable freeze: drop en for 5 cycles during UNLOCK → unlock high for 13 cycles total, with fail_count and the timer held.
- Early exit and counter clearing:
  - relock during UNLOCK cycle 3 → unlock low on the next edge.
  - Separately, two fails then a correct code → fail_count back to 0.
- rst asserted in LOCKOUT cycle 6 → all outputs 0 next edge. With LOCK_ALARM_EN: alarm toggles at lockout cycles 4, 8 and 12, and is 0 after reset.
